// File: rtl/mem_access_unit_if.sv
// IO bus between the M-stage memory access unit (master) and an IO device (slave).
// io_addr/io_wdata/io_be/io_we are valid while io_req is high; io_rdata is valid with io_ack.
interface mem_access_unit_if;
    logic        io_req;
    logic        io_we;
    logic [31:0] io_addr;
    logic [31:0] io_wdata;
    logic [3:0]  io_be;
    logic        io_ack;
    logic [31:0] io_rdata;

    modport master (
        output io_req, io_we, io_addr, io_wdata, io_be,
        input  io_ack, io_rdata
    );

    modport slave (
        input  io_req, io_we, io_addr, io_wdata, io_be,
        output io_ack, io_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// M-stage memory/IO access: byte-lane data RAM, handshaked IO bus with pipeline stall, load extension.
// Optional IO bus timeout (bus_err pulse) is built when the macro IO_TIMEOUT_EN is defined.
module mem_access_unit #(
    parameter int MEM_WORDS  = 2048,
    parameter int IO_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic [1:0]         BeOP,
    input  logic [2:0]         MeOP,
    input  logic               MemWrite,
    input  logic               IOWrite,
    input  logic               now_device,
    mem_access_unit_if.master  bus,
    output logic [31:0]        rdata_W,
    output logic               stall,
    output logic               align_exc,
    output logic               bus_err
);
    localparam logic [1:0] BE_SB  = 2'b01;
    localparam logic [1:0] BE_SH  = 2'b10;
    localparam logic [1:0] BE_SW  = 2'b11;
    localparam logic [2:0] ME_NONE = 3'b000;
    localparam logic [2:0] ME_LB   = 3'b001;
    localparam logic [2:0] ME_LBU  = 3'b010;
    localparam logic [2:0] ME_LH   = 3'b011;
    localparam logic [2:0] ME_LHU  = 3'b100;
    localparam logic [2:0] ME_LW   = 3'b101;
    localparam logic       NOWDEVICE_IO = 1'b1;
    localparam int         IDX_W = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t           r_state, w_state_next;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata_rep;
    logic             w_half, w_word, w_io_access, w_mem_we;
    logic             w_launch, w_finish, w_timeout;
    logic [IDX_W-1:0] w_idx;
    logic [31:0]      w_ram_word, w_load_word, w_load_val;
    logic [31:0]      r_mem [MEM_WORDS];
    logic             r_io_req, r_io_we, r_bus_err;
    logic [3:0]       r_io_be;
    logic [31:0]      r_io_addr, r_io_wdata, r_cap, r_rdata_W;

    function automatic logic [31:0] extend(input logic [2:0] op, input logic [31:0] word,
                                           input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            ME_LB:   return {{24{b[7]}}, b};
            ME_LBU:  return {24'h0, b};
            ME_LH:   return {{16{h[15]}}, h};
            ME_LHU:  return {16'h0, h};
            ME_LW:   return word;
            default: return 32'h0;
        endcase
    endfunction

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_be        = 4'b0000;
        w_wdata_rep = wdata;
        case (BeOP)
            BE_SB: begin
                w_be        = 4'b0001 << addr[1:0];
                w_wdata_rep = {4{wdata[7:0]}};
            end
            BE_SH: begin
                w_be        = 4'b0011 << {addr[1], 1'b0};
                w_wdata_rep = {2{wdata[15:0]}};
            end
            BE_SW:   w_be = 4'b1111;
            default: ;
        endcase
    end

    assign w_half      = (BeOP == BE_SH) | (MeOP == ME_LH) | (MeOP == ME_LHU);
    assign w_word      = (BeOP == BE_SW) | (MeOP == ME_LW);
    assign align_exc   = (w_half & addr[0]) | (w_word & (addr[1:0] != 2'b00));
    assign w_io_access = !align_exc & (IOWrite | ((MeOP != ME_NONE) & (now_device == NOWDEVICE_IO)));

    assign w_idx      = addr[IDX_W+1:2];
    assign w_ram_word = r_mem[w_idx];
    assign w_mem_we   = MemWrite & !align_exc & !stall;

    // NOTE: the data RAM has no reset so it maps onto block RAM; contents are undefined until written.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

`ifdef IO_TIMEOUT_EN
    localparam int CNT_W = (IO_TIMEOUT < 16) ? 4 : $clog2(IO_TIMEOUT + 1);
    logic [CNT_W-1:0] r_to_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_to_cnt <= '0;
        else if (r_state == S_REQ)  r_to_cnt <= r_to_cnt + CNT_W'(1);
        else                        r_to_cnt <= '0;
    end

    assign w_timeout = (r_state == S_REQ) & !bus.io_ack & (r_to_cnt == CNT_W'(IO_TIMEOUT - 1));
`else
    assign w_timeout = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_io_access) w_state_next = S_REQ;
            S_REQ:   if (bus.io_ack | w_timeout) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // The DONE cycle releases the stall so the held instruction retires with the captured data.
    always_comb begin
        stall    = w_io_access & (r_state != S_DONE);
        w_launch = (r_state == S_IDLE) & w_io_access;
        w_finish = (r_state == S_REQ) & (bus.io_ack | w_timeout);
    end

    assign w_load_word = (r_state == S_DONE) ? r_cap : w_ram_word;
    assign w_load_val  = align_exc ? 32'h0 : extend(MeOP, w_load_word, addr[1:0]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_io_req   <= 1'b0;
            r_io_we    <= 1'b0;
            r_io_be    <= 4'h0;
            r_io_addr  <= 32'h0;
            r_io_wdata <= 32'h0;
            r_cap      <= 32'h0;
            r_rdata_W  <= 32'h0;
            r_bus_err  <= 1'b0;
        end else begin
            r_io_req  <= (w_state_next == S_REQ);
            r_bus_err <= w_timeout;
            if (w_launch) begin
                r_io_addr  <= addr;
                r_io_wdata <= w_wdata_rep;
                r_io_be    <= w_be;
                r_io_we    <= IOWrite;
            end
            if (w_finish) r_cap <= w_timeout ? 32'h0 : bus.io_rdata;
            if (!stall)   r_rdata_W <= w_load_val;
        end
    end

    assign bus.io_req   = r_io_req;
    assign bus.io_we    = r_io_we;
    assign bus.io_be    = r_io_be;
    assign bus.io_addr  = r_io_addr;
    assign bus.io_wdata = r_io_wdata;
    assign rdata_W      = r_rdata_W;
    assign bus_err      = r_bus_err;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized RAM and IO traffic
// checked against a byte-addressed reference model.
module tb_mem_access_unit;
    localparam logic [1:0] BE_NONE = 2'b00, BE_SB = 2'b01, BE_SH = 2'b10, BE_SW = 2'b11;
    localparam logic [2:0] ME_NONE = 3'd0, ME_LB = 3'd1, ME_LBU = 3'd2, ME_LH = 3'd3, ME_LHU = 3'd4, ME_LW = 3'd5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0, wdata = '0;
    logic [1:0]  BeOP = '0;
    logic [2:0]  MeOP = '0;
    logic        MemWrite = 1'b0, IOWrite = 1'b0, now_device = 1'b0;
    logic [31:0] rdata_W;
    logic        stall, align_exc, bus_err;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] mem_b [256];

    mem_access_unit_if bus ();

    mem_access_unit #(.MEM_WORDS(2048), .IO_TIMEOUT(15)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .BeOP(BeOP), .MeOP(MeOP),
        .MemWrite(MemWrite), .IOWrite(IOWrite), .now_device(now_device), .bus(bus),
        .rdata_W(rdata_W), .stall(stall), .align_exc(align_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int store_size(input logic [1:0] be);
        case (be)
            BE_SB: return 1;
            BE_SH: return 2;
            BE_SW: return 4;
            default: return 0;
        endcase
    endfunction

    function automatic int load_size(input logic [2:0] me);
        case (me)
            ME_LB, ME_LBU: return 1;
            ME_LH, ME_LHU: return 2;
            ME_LW:         return 4;
            default:       return 0;
        endcase
    endfunction

    function automatic logic model_align(input logic [1:0] be, input logic [2:0] me, input logic [31:0] a);
        int ss = store_size(be);
        int ls = load_size(me);
        int off = int'(a[1:0]);
        return ((ss > 1) && (off % ss != 0)) || ((ls > 1) && (off % ls != 0));
    endfunction

    // Value loaded from a little-endian word at byte offset off, sign-extended for LB/LH.
    function automatic logic [31:0] model_extend(input logic [2:0] me, input logic [31:0] word, input int off);
        int n = load_size(me);
        longint v = 0;
        for (int k = 0; k < n; k++) v += longint'((word >> (8 * (off + k))) & 32'hFF) << (8 * k);
        if ((me == ME_LB || me == ME_LH) && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        int base = int'(a[7:2]) * 4;
        return {mem_b[base + 3], mem_b[base + 2], mem_b[base + 1], mem_b[base]};
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] be, input logic [31:0] a);
        int n = store_size(be);
        int m = ((1 << n) - 1) << int'(a[1:0]);
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_lanes(input logic [1:0] be, input logic [31:0] wd);
        int n = store_size(be);
        logic [31:0] r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
        return r;
    endfunction

    task automatic model_store(input logic [1:0] be, input logic [31:0] a, input logic [31:0] wd);
        int n = store_size(be);
        for (int k = 0; k < n; k++) mem_b[int'(a[7:0]) + k] = wd[8*k +: 8];
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_inputs(input logic [1:0] be, input logic [2:0] me, input logic mw, input logic iow,
                              input logic dev, input logic [31:0] a, input logic [31:0] wd);
        BeOP = be; MeOP = me; MemWrite = mw; IOWrite = iow; now_device = dev; addr = a; wdata = wd;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drives one IO access and acts as the IO slave: ack is raised on REQ cycle ack_after+1.
    // Returns at 1 time unit after the edge that leaves DONE, with rdata_W updated.
    task automatic run_io(input logic [2:0] me, input logic [1:0] be, input logic [31:0] a,
                          input logic [31:0] wd, input int ack_after, input logic [31:0] rd,
                          output int stall_cyc, output int req_cyc, output int err_cyc,
                          output logic bus_ok, output logic done);
        logic iow;
        iow = (be != BE_NONE);
        set_inputs(be, me, 1'b0, iow, 1'b1, a, wd);
        bus.io_ack = 1'b0;
        bus.io_rdata = $urandom;
        stall_cyc = 0; req_cyc = 0; err_cyc = 0; bus_ok = 1'b1; done = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            bus.io_ack = 1'b0;
            if (stall) stall_cyc++;
            if (bus_err) err_cyc++;
            if (bus.io_req) begin
                req_cyc++;
                if (bus.io_addr !== a || bus.io_we !== iow) bus_ok = 1'b0;
                if (iow && (bus.io_be !== model_be(be, a) || bus.io_wdata !== model_lanes(be, wd))) bus_ok = 1'b0;
                if (req_cyc == ack_after + 1) begin
                    bus.io_ack = 1'b1;
                    bus.io_rdata = rd;
                end
            end
            if (!stall) begin
                done = 1'b1;
                break;
            end
        end
        step();
        bus.io_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.io_ack = 1'b0;
        bus.io_rdata = 32'h0;
        #1 reset = 1'b0;
        repeat (2) step();
        n_checks++;
        if ({bus.io_req, bus.io_we, bus.io_be} !== 6'h0) begin
            n_errors++; $display("FAIL reset_io_ctrl: got %0h expected 0", {bus.io_req, bus.io_we, bus.io_be});
        end
        n_checks++;
        if (bus.io_addr !== 32'h0 || bus.io_wdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_io_data: got addr=%h wdata=%h expected 0", bus.io_addr, bus.io_wdata);
        end
        n_checks++;
        if (rdata_W !== 32'h0) begin n_errors++; $display("FAIL reset_rdata_W: got %h expected 0", rdata_W); end
        n_checks++;
        if (stall !== 1'b0 || bus_err !== 1'b0) begin
            n_errors++; $display("FAIL reset_stall_err: got stall=%b bus_err=%b expected 0 0", stall, bus_err);
        end
        @(negedge clk) reset = 1'b1;
        // io_ack while idle must be ignored
        bus.io_ack = 1'b1;
        step();
        step();
        n_checks++;
        if (bus.io_req !== 1'b0 || stall !== 1'b0) begin
            n_errors++; $display("FAIL idle_ack_ignored: got io_req=%b stall=%b expected 0 0", bus.io_req, stall);
        end
        bus.io_ack = 1'b0;
    endtask

    task automatic test_mem_directed;
        logic [2:0]  t_me  [4] = '{ME_LB, ME_LBU, ME_LH, ME_LHU};
        logic [31:0] t_a   [4] = '{32'h20, 32'h20, 32'h22, 32'h22};
        logic [31:0] t_exp [4] = '{32'hFFFFFFFF, 32'h000000FF, 32'hFFFF8000, 32'h00008000};
        set_inputs(BE_SW, ME_NONE, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0);          step();
        set_inputs(BE_SB, ME_NONE, 1'b1, 1'b0, 1'b0, 32'h13, 32'h000000AB);   step();
        set_inputs(BE_NONE, ME_LW, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);          step();
        n_checks++;
        if (rdata_W !== 32'hAB000000) begin n_errors++; $display("FAIL sb_then_lw: got %h expected ab000000", rdata_W); end
        model_store(BE_SW, 32'h10, 32'hAB000000);
        set_inputs(BE_SW, ME_NONE, 1'b1, 1'b0, 1'b0, 32'h20, 32'h8000F0FF);   step();
        model_store(BE_SW, 32'h20, 32'h8000F0FF);
        for (int i = 0; i < 4; i++) begin
            set_inputs(BE_NONE, t_me[i], 1'b0, 1'b0, 1'b0, t_a[i], 32'h0);
            step();
            n_checks++;
            if (rdata_W !== t_exp[i]) begin
                n_errors++; $display("FAIL load_ext_%0d: got %h expected %h", i, rdata_W, t_exp[i]);
            end
        end
        set_inputs(BE_SW, ME_NONE, 1'b1, 1'b0, 1'b0, 32'h04, 32'h00000055);   step();
        model_store(BE_SW, 32'h04, 32'h00000055);
        set_inputs(BE_SW, ME_NONE, 1'b1, 1'b0, 1'b0, 32'h06, 32'hDEADBEEF);
        #1;
        n_checks++;
        if (align_exc !== 1'b1 || stall !== 1'b0) begin
            n_errors++; $display("FAIL sw_misaligned: got align_exc=%b stall=%b expected 1 0", align_exc, stall);
        end
        step();
        set_inputs(BE_NONE, ME_LW, 1'b0, 1'b0, 1'b0, 32'h04, 32'h0);          step();
        n_checks++;
        if (rdata_W !== 32'h00000055) begin n_errors++; $display("FAIL sw_misaligned_no_write: got %h expected 55", rdata_W); end
        set_inputs(BE_NONE, ME_LH, 1'b0, 1'b0, 1'b1, 32'h21, 32'h0);
        #1;
        n_checks++;
        if (align_exc !== 1'b1 || stall !== 1'b0) begin
            n_errors++; $display("FAIL lh_misaligned: got align_exc=%b stall=%b expected 1 0", align_exc, stall);
        end
        step();
        n_checks++;
        if (rdata_W !== 32'h0) begin n_errors++; $display("FAIL lh_misaligned_rdata: got %h expected 0", rdata_W); end
    endtask

    task automatic test_mem_random;
        logic [31:0] a, wd, exp_rd;
        logic [1:0]  be;
        logic [2:0]  me;
        logic        mw, exp_align;
        int          kind;
        for (int w = 0; w < 64; w++) begin
            wd = $urandom;
            set_inputs(BE_SW, ME_NONE, 1'b1, 1'b0, 1'b0, 32'(w * 4), wd);
            step();
            model_store(BE_SW, 32'(w * 4), wd);
        end
        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, 255));
            wd = $urandom;
            kind = $urandom_range(0, 2);
            be = BE_NONE; me = ME_NONE; mw = 1'b0;
            if (kind == 0) begin be = 2'($urandom_range(1, 3)); mw = 1'b1; end
            else if (kind == 1) me = 3'($urandom_range(1, 5));
            exp_align = model_align(be, me, a);
            exp_rd = (me == ME_NONE || exp_align) ? 32'h0 : model_extend(me, model_word(a), int'(a[1:0]));
            set_inputs(be, me, mw, 1'b0, 1'b0, a, wd);
            #1;
            n_checks++;
            if (align_exc !== exp_align || stall !== 1'b0) begin
                n_errors++; $display("FAIL rand_align[%0d]: got align=%b stall=%b expected %b 0 (a=%h be=%0d me=%0d)", i, align_exc, stall, exp_align, a, be, me);
            end
            step();
            n_checks++;
            if (rdata_W !== exp_rd) begin
                n_errors++; $display("FAIL rand_load[%0d]: got %h expected %h (a=%h me=%0d)", i, rdata_W, exp_rd, a, me);
            end
            if (mw && !exp_align) model_store(be, a, wd);
        end
    endtask

    task automatic test_io_load;
        int sc, rc, ec;
        logic ok, done;
        run_io(ME_LW, BE_NONE, 32'h100, 32'h0, 3, 32'h12345678, sc, rc, ec, ok, done);
        n_checks++;
        if (!done || sc != 5 || rc != 4) begin
            n_errors++; $display("FAIL io_load_timing: got done=%b stall=%0d req=%0d expected 1 5 4", done, sc, rc);
        end
        n_checks++;
        if (rdata_W !== 32'h12345678) begin n_errors++; $display("FAIL io_load_data: got %h expected 12345678", rdata_W); end
        n_checks++;
        if (!ok || ec != 0) begin n_errors++; $display("FAIL io_load_bus: got bus_ok=%b bus_err_cycles=%0d expected 1 0", ok, ec); end
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_io_write_reset;
        set_inputs(BE_SH, ME_NONE, 1'b0, 1'b1, 1'b1, 32'h7F02, 32'h0000BEEF);
        step();
        n_checks++;
        if (bus.io_req !== 1'b1 || bus.io_we !== 1'b1 || bus.io_be !== 4'b1100) begin
            n_errors++; $display("FAIL io_sh_ctrl: got req=%b we=%b be=%b expected 1 1 1100", bus.io_req, bus.io_we, bus.io_be);
        end
        n_checks++;
        if (bus.io_wdata !== 32'hBEEFBEEF || bus.io_addr !== 32'h7F02) begin
            n_errors++; $display("FAIL io_sh_data: got wdata=%h addr=%h expected beefbeef 00007f02", bus.io_wdata, bus.io_addr);
        end
        #3 reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.io_req, bus.io_we, bus.io_be} !== 6'h0 || bus.io_addr !== 32'h0 || bus.io_wdata !== 32'h0) begin
            n_errors++; $display("FAIL reset_mid_req: got req=%b we=%b be=%b addr=%h expected all 0", bus.io_req, bus.io_we, bus.io_be, bus.io_addr);
        end
        n_checks++;
        if (stall !== 1'b1) begin n_errors++; $display("FAIL reset_stall_follows: got %b expected 1", stall); end
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 reset = 1'b1;
        step();
        n_checks++;
        if (bus.io_req !== 1'b0 || stall !== 1'b0) begin
            n_errors++; $display("FAIL after_reset_idle: got req=%b stall=%b expected 0 0", bus.io_req, stall);
        end
    endtask

    task automatic test_back_to_back;
        int sc, rc, ec;
        logic ok, done;
        logic [31:0] rd;
        for (int i = 0; i < 2; i++) begin
            rd = $urandom;
            run_io(ME_LW, BE_NONE, 32'h300 + 32'(4 * i), 32'h0, 0, rd, sc, rc, ec, ok, done);
            n_checks++;
            if (!done || sc != 2 || rc != 1 || !ok || rdata_W !== rd) begin
                n_errors++; $display("FAIL back_to_back[%0d]: got done=%b stall=%0d req=%0d ok=%b rdata=%h expected 1 2 1 1 %h", i, done, sc, rc, ok, rdata_W, rd);
            end
        end
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

    task automatic test_io_random;
        int sc, rc, ec, ack, n;
        logic ok, done;
        logic [31:0] a, wd, rd, exp_rd;
        logic [1:0] be;
        logic [2:0] me;
        for (int i = 0; i < 20; i++) begin
            wd = $urandom; rd = $urandom; ack = $urandom_range(0, 5);
            be = BE_NONE; me = ME_NONE;
            if ($urandom_range(0, 1) == 0) begin
                me = 3'($urandom_range(1, 5)); n = load_size(me);
            end else begin
                be = 2'($urandom_range(1, 3)); n = store_size(be);
            end
            a = $urandom & ~32'(n - 1);
            exp_rd = (me == ME_NONE) ? 32'h0 : model_extend(me, rd, int'(a[1:0]));
            run_io(me, be, a, wd, ack, rd, sc, rc, ec, ok, done);
            n_checks++;
            if (!done || sc != ack + 2 || rc != ack + 1) begin
                n_errors++; $display("FAIL io_rand_timing[%0d]: got done=%b stall=%0d req=%0d expected 1 %0d %0d", i, done, sc, rc, ack + 2, ack + 1);
            end
            n_checks++;
            if (!ok || ec != 0) begin
                n_errors++; $display("FAIL io_rand_bus[%0d]: got bus_ok=%b bus_err_cycles=%0d expected 1 0 (a=%h be=%0d)", i, ok, ec, a, be);
            end
            n_checks++;
            if (rdata_W !== exp_rd) begin
                n_errors++; $display("FAIL io_rand_rdata[%0d]: got %h expected %h (me=%0d a=%h)", i, rdata_W, exp_rd, me, a);
            end
        end
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask

`ifdef IO_TIMEOUT_EN
    task automatic test_timeout;
        int sc, rc, ec;
        logic ok, done;
        step();
        n_checks++;
        if (rdata_W !== 32'h0) begin n_errors++; $display("FAIL timeout_pre: got %h expected 0", rdata_W); end
        set_inputs(BE_NONE, ME_LW, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0);
        step();
        run_io(ME_LW, BE_NONE, 32'h200, 32'h0, 1000, 32'hFFFFFFFF, sc, rc, ec, ok, done);
        n_checks++;
        if (!done || rc != 15 || sc != 16) begin
            n_errors++; $display("FAIL timeout_timing: got done=%b req=%0d stall=%0d expected 1 15 16", done, rc, sc);
        end
        n_checks++;
        if (ec != 1) begin n_errors++; $display("FAIL timeout_bus_err: got %0d pulses expected 1", ec); end
        n_checks++;
        if (rdata_W !== 32'h0) begin n_errors++; $display("FAIL timeout_rdata: got %h expected 0", rdata_W); end
        set_inputs(BE_NONE, ME_NONE, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_mem_directed();
        test_mem_random();
        test_io_load();
        test_io_write_reset();
        test_back_to_back();
        test_io_random();
`ifdef IO_TIMEOUT_EN
        test_timeout();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- M-stage memory/IO datapath, directly downstream of the M-stage control decoder.
- Consumes BeOP, MeOP, MemWrite, IOWrite and now_device.
- Drives the on-chip data RAM and a handshaked IO bus, stalls the pipeline during IO transactions, and delivers sign/zero-extended load data into the M/W pipeline register.

Parameters:
- MEM_WORDS, 2048: data RAM depth in 32-bit words; index = addr[log2(MEM_WORDS)+1:2].
- IO_TIMEOUT, 15: max cycles waiting for io_ack (used only with the optional feature).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-low.
- addr  input  32  byte address from ALU result (M stage).
- wdata  input  32  store data (rt, forwarded).
- BeOP  input  2  store width: 00 none, `BE_SB=01, `BE_SH=10, `BE_SW=11.
- MeOP  input  3  load type: 000 none, `ME_LB=001, `ME_LBU=010, `ME_LH=011, `ME_LHU=100, `ME_LW=101.
- MemWrite  input  1  store targets RAM.
- IOWrite  input  1  store targets IO.
- now_device  input  1  `NOWDEVICE_MEMO=0, `NOWDEVICE_IO=1 (selects load source).
- io_ack  input  1  IO device completion.
- io_rdata  input  32  IO read data, valid with io_ack.
- rdata_W  output  32  registered, extended load data for W stage.
- stall  output  1  freeze F/D/E/M stages.
- align_exc  output  1  misaligned access (combinational).
- io_req  output  1  IO request (registered).
- io_we  output  1  IO write strobe, valid with io_req.
- io_addr  output  32  registered address.
- io_wdata  output  32  registered lane-shifted data.
- io_be  output  4  registered byte enables.
- bus_err  output  1  one-cycle pulse on IO timeout (feature only, else tied 0).

Behaviour:
- Little-endian lanes. be = SB: 4'b0001<<addr[1:0]; SH: 4'b0011<<{addr[1],1'b0}; SW: 4'b1111. Store data replicated: SB {4{wdata[7:0]}}, SH {2{wdata[15:0]}}.
- align_exc = (SH or LH/LHU with addr[0]=1) or (SW/LW with addr[1:0]!=0). When set: no RAM write, no IO request, stall=0, rdata_W loads 0.
- RAM: write on clk edge when MemWrite & !align_exc & !stall, masked by be. Read is combinational on the word index. RAM is not reset.
- Load path: select byte/half by addr[1:0]/addr[1], extend per MeOP. rdata_W <= extended value each unstalled cycle. Latency 1 cycle (M -> W). rdata_W = 0 when MeOP=000.
- io_access = !align_exc & (IOWrite | (MeOP!=0 & now_device==IO)).
- FSM states IDLE, REQ, DONE:
  - IDLE: if io_access -> REQ. Latch io_addr, io_wdata, io_be, io_we=IOWrite. io_req<=1.
  - REQ: hold io_req and all io_* stable until io_ack. On io_ack: capture io_rdata, io_req<=0, -> DONE.
  - DONE: one cycle. rdata_W <= extended captured data. -> IDLE.
- stall = io_access & (state!=DONE). It is asserted in the same cycle the access appears. A back-to-back IO access in the next instruction re-enters REQ from IDLE (minimum 3 cycles per IO access).
- io_ack in IDLE/DONE: ignored.
- Reset (any time, including mid-REQ): state=IDLE. io_req, io_we, io_be, io_addr, io_wdata, rdata_W, bus_err = 0 immediately. stall follows inputs.

Optional Feature:
- IO_TIMEOUT_EN defined:
  - A 4-bit+ counter clears on entry to REQ and increments each REQ cycle.
  - Reaching IO_TIMEOUT without io_ack: io_req<=0, bus_err pulses 1 cycle, captured data = 0, -> DONE.
- Undefined: no counter; REQ waits indefinitely; bus_err tied 0.

Test Plan:
- SB wdata=0x000000AB addr=0x13 MemWrite=1, then LW addr=0x10 -> RAM word byte3=0xAB, other bytes unchanged; rdata_W = 0xAB000000 one cycle later.
- Word at 0x20 = 0x8000F0FF. LB addr=0x20 -> 0xFFFFFFFF. LBU -> 0x000000FF. LH addr=0x22 -> 0xFFFF8000. LHU addr=0x22 -> 0x00008000.
- SW addr=0x06 -> align_exc=1, no RAM change, stall=0. LH addr=0x21 -> align_exc=1, rdata_W=0.
- IO load (now_device=1, MeOP=LW) with io_ack after 3 cycles, io_rdata=0x12345678 -> stall high 5 cycles (IDLE + 3 REQ + ack cycle), low in DONE; rdata_W=0x12345678; io_req high 4 cycles.
- IOWrite SH addr=0x7F02 wdata=0xBEEF -> io_be=4'b1100, io_wdata=0xBEEFBEEF, io_we=1. Assert reset mid-REQ -> io_req drops asynchronously, state IDLE.
- With IO_TIMEOUT_EN, no io_ack -> after 15 REQ cycles bus_err pulses once, rdata_W=0, stall releases.
